mult_scheduler: RTL and testbench



---
 rtl/mult_sched_pkg.sv | 34 +++
 rtl/mult_scheduler_rr_picker.sv | 37 +++
 rtl/mult_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_mult_scheduler.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_sched_pkg.sv
// Package shared by the multiplier scheduler files.
// Holds the scheduler state encoding, the tag-width helper and the
// round-robin pointer reset helper.
// The optional timeout feature is selected elsewhere by MULT_SCHED_TIMEOUT_EN.
package mult_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    BUSY    = 2'd2,
    DELIVER = 2'd3
  } sched_state_t;

  localparam int NREQ_DEFAULT = 32'sd4;

  // Width of a requester index; a single requester still gets a 1-bit tag.
  function automatic int calc_tag_w(input int n);
    if (n > 32'sd1) begin
      return $clog2(n);
    end else begin
      return 32'sd1;
    end
  endfunction

  localparam int TAG_W = calc_tag_w(NREQ_DEFAULT);

  // The pointer resets to the last requester so requester 0 wins first.
  function automatic int rr_ptr_rst(input int n);
    return n - 32'sd1;
  endfunction

  localparam int RR_PTR_RST_DEFAULT = rr_ptr_rst(NREQ_DEFAULT);

endpackage

// File: rtl/mult_scheduler_rr_picker.sv
// Combinational round-robin picker.
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - index of the last winner; the search starts at ptr+1
//   grant - one-hot grant (all zero when no request is pending)
//   idx   - encoded index of the granted requester
//   any   - at least one request is pending
module rr_picker
  import mult_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int TW   = calc_tag_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [TW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [TW-1:0]   idx,
  output logic            any
);

  // First pending request after ptr, with modulo-NREQ wrap.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 32'sd1; k <= NREQ; k++) begin
      if (!any && req[TW'((int'(ptr) + k) % NREQ)]) begin
        grant[TW'((int'(ptr) + k) % NREQ)] = 1'b1;
        idx = TW'((int'(ptr) + k) % NREQ);
        any = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/mult_scheduler.sv
// Shares one signed multiplier core among NREQ requesters using
// round-robin arbitration. One job is in flight at a time: operands are
// latched on accept, the core is started with a one-cycle mul_valid pulse,
// the product is captured on mul_done and returned to the owning requester
// over a valid/ready handshake.
// Optional feature macro: MULT_SCHED_TIMEOUT_EN -- aborts a job that sees no
// mul_done within TIMEOUT BUSY cycles, returning 0 with resp_err set.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   req_valid/req_ready      - per-requester request handshake (ready one-hot)
//   req_a/req_b              - flattened signed operands, slice i = requester i
//   resp_valid/resp_ready    - per-requester response handshake (valid one-hot)
//   resp_data, resp_err      - shared product and timeout-abort flag
//   mul_valid, mul_a, mul_b  - start pulse and operands to the core
//   mul_y, mul_done          - core product and completion pulse
module mult_scheduler
  import mult_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   resp_valid,
  input  logic [NREQ-1:0]   resp_ready,
  output logic [2*W-1:0]    resp_data,
  output logic              resp_err,
  output logic              mul_valid,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  input  logic [2*W-1:0]    mul_y,
  input  logic              mul_done
);

  localparam int TW = calc_tag_w(NREQ);
  localparam logic [TW-1:0] RR_PTR_RST = TW'(rr_ptr_rst(NREQ));
  localparam logic [NREQ-1:0] ONE_N = {{(NREQ-1){1'b0}}, 1'b1};

  sched_state_t      state_q, state_d;
  logic [TW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]     tag_q, tag_d;
  logic [W-1:0]      mul_a_q, mul_a_d;
  logic [W-1:0]      mul_b_q, mul_b_d;
  logic              mul_valid_q, mul_valid_d;
  logic [NREQ-1:0]   resp_valid_q, resp_valid_d;
  logic [2*W-1:0]    resp_data_q, resp_data_d;

  logic [NREQ-1:0]   pick_grant;
  logic [TW-1:0]     pick_idx;
  logic              pick_any;

`ifdef MULT_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              resp_err_q, resp_err_d;
`endif

  rr_picker #(
    .NREQ (NREQ),
    .TW   (TW)
  ) u_picker (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Accept is combinational so the winner sees req_ready in its request cycle.
  assign req_ready  = (state_q == IDLE) ? pick_grant : '0;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign mul_valid  = mul_valid_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
`ifdef MULT_SCHED_TIMEOUT_EN
  assign resp_err   = resp_err_q;
`else
  assign resp_err   = 1'b0;
`endif

  // Next-state and next-output computation for the job sequencer.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    tag_d        = tag_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    mul_valid_d  = 1'b0;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
`ifdef MULT_SCHED_TIMEOUT_EN
    cnt_d        = cnt_q;
    resp_err_d   = resp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          mul_a_d     = req_a[int'(pick_idx)*W +: W];
          mul_b_d     = req_b[int'(pick_idx)*W +: W];
          tag_d       = pick_idx;
          rr_ptr_d    = pick_idx;
          mul_valid_d = 1'b1;  // high for the single ISSUE cycle
          state_d     = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = BUSY;
`ifdef MULT_SCHED_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      BUSY: begin
        if (mul_done) begin
          resp_data_d  = mul_y;
          resp_valid_d = ONE_N << tag_q;
          state_d      = DELIVER;
`ifdef MULT_SCHED_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th BUSY cycle without completion.
          resp_data_d  = '0;
          resp_err_d   = 1'b1;
          resp_valid_d = ONE_N << tag_q;
          state_d      = DELIVER;
        end else begin
          cnt_d = cnt_q + CW'(1);
`else
        end else begin
          state_d = BUSY;
`endif
        end
      end
      DELIVER: begin
        // Only the owner's resp_ready matters.
        if (resp_ready[tag_q]) begin
          resp_valid_d = '0;
          state_d      = IDLE;
`ifdef MULT_SCHED_TIMEOUT_EN
          resp_err_d   = 1'b0;
`endif
        end else begin
          state_d = DELIVER;
        end
      end
      default: begin
        state_d      = IDLE;
        resp_valid_d = '0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= RR_PTR_RST;
      tag_q        <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_valid_q  <= 1'b0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
`ifdef MULT_SCHED_TIMEOUT_EN
      cnt_q        <= '0;
      resp_err_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      tag_q        <= tag_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      mul_valid_q  <= mul_valid_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
`ifdef MULT_SCHED_TIMEOUT_EN
      cnt_q        <= cnt_d;
      resp_err_q   <= resp_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_mult_scheduler.sv
// Directed self-checking bench for mult_scheduler (NREQ=4, W=8, TIMEOUT=64).
// The bench plays the multiplier core: it answers mul_valid with a product
// pulse after a chosen latency.
module tb_mult_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  resp_valid;
  logic [3:0]  resp_ready;
  logic [15:0] resp_data;
  logic        resp_err;
  logic        mul_valid;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [15:0] mul_y;
  logic        mul_done;

  int n_checks;
  int n_errors;

  logic [7:0]  ta [4];
  logic [7:0]  tbv [4];
  logic [15:0] ty [4];

  mult_scheduler #(
    .NREQ    (4),
    .W       (8),
    .TIMEOUT (64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .mul_valid  (mul_valid),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_y      (mul_y),
    .mul_done   (mul_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ops();
    req_a = {ta[3], ta[2], ta[1], ta[0]};
    req_b = {tbv[3], tbv[2], tbv[1], tbv[0]};
  endtask

  // Acts as the core for one job; returns just after the edge entering DELIVER.
  task automatic serve_core(input logic [7:0] ea, input logic [7:0] eb, input int lat);
    int n;
    logic signed [15:0] pa;
    logic signed [15:0] pb;
    n = 0;
    @(negedge clk);
    while (mul_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mul_valid_seen", 32'(mul_valid), 32'd1);
    chk("mul_a", 32'(mul_a), 32'(ea));
    chk("mul_b", 32'(mul_b), 32'(eb));
    tick();
    @(negedge clk);
    chk("mul_valid_pulse", 32'(mul_valid), 32'd0);
    repeat (lat) tick();
    chk("mul_a_hold", 32'(mul_a), 32'(ea));
    pa = {{8{mul_a[7]}}, mul_a};
    pb = {{8{mul_b[7]}}, mul_b};
    mul_y = pa * pb;
    mul_done = 1'b1;
    tick();
    mul_done = 1'b0;
    mul_y = 16'h0000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    req_valid  = 4'b0000;
    resp_ready = 4'b0000;
    mul_y      = 16'h0000;
    mul_done   = 1'b0;
    ta[0] = 8'hFD; tbv[0] = 8'h05; ty[0] = 16'hFFF1;
    ta[1] = 8'h80; tbv[1] = 8'h80; ty[1] = 16'h4000;
    ta[2] = 8'h7F; tbv[2] = 8'h7F; ty[2] = 16'h3F01;
    ta[3] = 8'hFF; tbv[3] = 8'h01; ty[3] = 16'hFFFF;
    load_ops();
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mul_valid", 32'(mul_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    chk("rst_mul_ab", {16'd0, mul_a, mul_b}, 32'd0);

    // Single request: -3 * 5
    tick();
    req_valid = 4'b0001;
    @(negedge clk);
    chk("t1_req_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    serve_core(8'hFD, 8'h05, 2);
    @(negedge clk);
    chk("t1_resp_valid", 32'(resp_valid), 32'h1);
    chk("t1_resp_data", 32'(resp_data), 32'hFFF1);
    resp_ready = 4'b0001;
    tick();
    @(negedge clk);
    chk("t1_resp_clear", 32'(resp_valid), 32'h0);
    chk("t1_data_hold", 32'(resp_data), 32'hFFF1);

    // Round robin from reset: 0,1,2,3,0
    do_reset();
    ta[0] = 8'h07; tbv[0] = 8'hF8; ty[0] = 16'hFFC8;
    load_ops();
    resp_ready = 4'b1111;
    req_valid  = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("rr_grant", 32'(req_ready), 32'(4'b0001 << (j % 4)));
      tick();
      serve_core(ta[j % 4], tbv[j % 4], 1 + j);
      @(negedge clk);
      chk("rr_resp_valid", 32'(resp_valid), 32'(4'b0001 << (j % 4)));
      chk("rr_resp_data", 32'(resp_data), 32'(ty[j % 4]));
      if (j == 4) req_valid = 4'b0000;
      tick();
    end

    // Backpressure on requester 2; others' resp_ready must be ignored
    req_valid  = 4'b0100;
    resp_ready = 4'b0000;
    @(negedge clk);
    chk("bp_grant", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0000;
    serve_core(8'h7F, 8'h7F, 3);
    req_valid  = 4'b1011;
    resp_ready = 4'b1011;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("bp_resp_valid", 32'(resp_valid), 32'h4);
      chk("bp_resp_data", 32'(resp_data), 32'h3F01);
      chk("bp_no_accept", 32'(req_ready), 32'h0);
      tick();
    end
    resp_ready = 4'b0100;
    @(negedge clk);
    chk("bp_last_valid", 32'(resp_valid), 32'h4);
    chk("bp_last_noacc", 32'(req_ready), 32'h0);
    tick();
    @(negedge clk);
    chk("bp_next_grant", 32'(req_ready), 32'h8);
    tick();
    req_valid  = 4'b0000;
    resp_ready = 4'b1111;
    serve_core(8'hFF, 8'h01, 1);
    @(negedge clk);
    chk("bp_next_valid", 32'(resp_valid), 32'h8);
    chk("bp_next_data", 32'(resp_data), 32'hFFFF);
    tick();

    // Reset while BUSY
    req_valid = 4'b0010;
    @(negedge clk);
    chk("rb_grant", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("rb_mul_valid", 32'(mul_valid), 32'h1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rb_resp_valid", 32'(resp_valid), 32'h0);
    chk("rb_resp_data", 32'(resp_data), 32'h0);
    chk("rb_mul_ab", {16'd0, mul_a, mul_b}, 32'd0);
    chk("rb_mul_valid0", 32'(mul_valid), 32'h0);
    tick();
    mul_y    = 16'h1234;
    mul_done = 1'b1;
    tick();
    mul_done = 1'b0;
    mul_y    = 16'h0000;
    repeat (3) begin
      @(negedge clk);
      chk("rb_stray_valid", 32'(resp_valid), 32'h0);
      chk("rb_stray_data", 32'(resp_data), 32'h0);
      tick();
    end
    req_valid = 4'b0010;
    @(negedge clk);
    chk("rb_regrant", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b0000;
    serve_core(8'h80, 8'h80, 2);
    @(negedge clk);
    chk("rb_resp_valid1", 32'(resp_valid), 32'h2);
    chk("rb_resp_data1", 32'(resp_data), 32'h4000);
    tick();

    // Core never answers
    req_valid = 4'b0001;
    @(negedge clk);
    chk("to_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b1110;
    tick();  // ISSUE -> BUSY edge
`ifdef MULT_SCHED_TIMEOUT_EN
    resp_ready = 4'b0000;
    repeat (63) tick();
    @(negedge clk);
    chk("to_early", 32'(resp_valid), 32'h0);
    tick();
    @(negedge clk);
    chk("to_resp_valid", 32'(resp_valid), 32'h1);
    chk("to_resp_data", 32'(resp_data), 32'h0);
    chk("to_resp_err", 32'(resp_err), 32'h1);
    resp_ready = 4'b0001;
    req_valid  = 4'b0000;
    tick();
    @(negedge clk);
    chk("to_err_clear", 32'(resp_err), 32'h0);
    chk("to_valid_clear", 32'(resp_valid), 32'h0);
`else
    repeat (100) tick();
    @(negedge clk);
    chk("nto_resp_valid", 32'(resp_valid), 32'h0);
    chk("nto_resp_err", 32'(resp_err), 32'h0);
    chk("nto_no_accept", 32'(req_ready), 32'h0);
    chk("nto_hold_a", 32'(mul_a), 32'h07);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
